// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, slave selects and address-region constants for bus_arbiter
package bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam logic [4:0] SEL_NONE     = 5'b00000;
    localparam logic [4:0] SEL_RAM      = 5'b00001;
    localparam logic [4:0] SEL_GPIO_IN  = 5'b00010;
    localparam logic [4:0] SEL_GPIO_OUT = 5'b00100;
    localparam logic [4:0] SEL_PWM      = 5'b01000;

    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK      = 32'hFFFF_F000;
    localparam logic [31:0] GPIO_IN_BASE  = 32'h1000_0000;
    localparam logic [31:0] GPIO_OUT_BASE = 32'h1000_0010;
    localparam logic [31:0] PWM_BASE      = 32'h1000_0020;
    localparam logic [31:0] REG_MASK      = 32'hFFFF_FFF0;

endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: maps a byte address to the one-hot slave select (bit 4 reserved, always 0)
module bus_addr_decode
    import bus_pkg::*;
(
    input  logic [31:0] addr,
    output logic [4:0]  sel
);

    // first matching region wins; unmapped addresses select nothing
    always_comb
        sel = ((addr & RAM_MASK) == RAM_BASE)      ? SEL_RAM      :
              ((addr & REG_MASK) == GPIO_IN_BASE)  ? SEL_GPIO_IN  :
              ((addr & REG_MASK) == GPIO_OUT_BASE) ? SEL_GPIO_OUT :
              ((addr & REG_MASK) == PWM_BASE)      ? SEL_PWM      : SEL_NONE;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and single-beat sequencer; BUS_ARBITER_TIMEOUT_EN adds the ack timeout
module bus_arbiter
    import bus_pkg::*;
#(
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_we,
    output logic [4:0]  bSel,
    input  logic [31:0] bData,
    input  logic [4:0]  s_ack
);

    state_t      state, nstate;
    logic        owner, last, pick, req_any, we_q, acked, timeout_hit, busy, fin;
    logic [31:0] pick_addr;
    logic [4:0]  pick_sel;

    assign req_any   = m0_req | m1_req;
    assign pick      = (m0_req & m1_req) ? ~last : m1_req;
    assign pick_addr = pick ? m1_addr : m0_addr;
    assign acked     = |(s_ack & bSel);

    bus_addr_decode u_dec (
        .addr (pick_addr),
        .sel  (pick_sel)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [3:0] wait_cnt;

    // counts ACCESS cycles; zero whenever outside ACCESS so each entry starts clean
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wait_cnt <= 4'd0;
        else        wait_cnt <= (state == ACCESS) ? wait_cnt + 4'd1 : 4'd0;

    assign timeout_hit = (wait_cnt == TIMEOUT - 4'd1);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nstate;

    // next state: ack beats a coincident timeout
    always_comb begin
        nstate = IDLE;
        unique case (state)
            IDLE:    nstate = !req_any ? IDLE : (pick_sel == SEL_NONE) ? ERR : ACCESS;
            ACCESS:  nstate = acked ? DONE : timeout_hit ? ERR : ACCESS;
            default: nstate = IDLE;
        endcase
    end

    // latch the winning request, clear the slave side on leaving ACCESS, advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner   <= 1'b0;
            last    <= 1'b1;
            we_q    <= 1'b0;
            bSel    <= SEL_NONE;
            s_addr  <= '0;
            s_wdata <= '0;
            m_rdata <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                owner   <= pick;
                we_q    <= pick ? m1_we : m0_we;
                bSel    <= pick_sel;
                s_addr  <= (pick_sel == SEL_NONE) ? '0 : pick_addr;
                s_wdata <= pick ? m1_wdata : m0_wdata;
                m_rdata <= '0;
            end
            if (state == ACCESS && nstate != ACCESS) begin
                we_q    <= 1'b0;
                bSel    <= SEL_NONE;
                s_addr  <= '0;
                m_rdata <= acked ? bData : '0;
            end
            if (fin) last <= owner;
        end

    assign busy    = (state != IDLE);
    assign fin     = (state == DONE) || (state == ERR);
    assign m0_gnt  = busy & ~owner;
    assign m1_gnt  = busy & owner;
    assign m0_done = fin & ~owner;
    assign m1_done = fin & owner;
    assign m0_err  = (state == ERR) & ~owner;
    assign m1_err  = (state == ERR) & owner;
    assign s_we    = we_q & (|bSel);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (timeout checks follow BUS_ARBITER_TIMEOUT_EN)
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [31:0] m_rdata, s_addr, s_wdata, bData;
    logic        s_we;
    logic [4:0]  bSel, s_ack;
    int          vectors = 0;
    int          miscompares = 0;
    int          seen;

    bus_arbiter #(.TIMEOUT(4'd15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m0_we    (m0_we),
        .m1_we    (m1_we),
        .m0_addr  (m0_addr),
        .m1_addr  (m1_addr),
        .m0_wdata (m0_wdata),
        .m1_wdata (m1_wdata),
        .m0_gnt   (m0_gnt),
        .m1_gnt   (m1_gnt),
        .m0_done  (m0_done),
        .m1_done  (m1_done),
        .m0_err   (m0_err),
        .m1_err   (m1_err),
        .m_rdata  (m_rdata),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_we     (s_we),
        .bSel     (bSel),
        .bData    (bData),
        .s_ack    (s_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // called in the first ACCESS cycle: ack at once, check the done cycle, drop req, return in IDLE
    task automatic serve(input logic mst, input logic [4:0] sel, input logic [31:0] rd, input string tag);
        chk({tag, "_gnt"}, 32'({m1_gnt, m0_gnt}), mst ? 32'h2 : 32'h1);
        chk({tag, "_sel"}, 32'(bSel), 32'(sel));
        s_ack = sel;
        bData = rd;
        cyc();
        chk({tag, "_done"}, 32'({m1_done, m0_done, m1_err, m0_err}), mst ? 32'h8 : 32'h4);
        chk({tag, "_rdata"}, m_rdata, rd);
        s_ack = 5'b0;
        if (mst) m1_req = 1'b0;
        else     m0_req = 1'b0;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        bData = '0; s_ack = 5'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
        chk("rst_done", 32'({m1_done, m0_done, m1_err, m0_err}), 32'h0);
        chk("rst_sel", 32'(bSel), 32'h0);
        chk("rst_we", 32'(s_we), 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_wdata", s_wdata, 32'h0);
        chk("rst_rdata", m_rdata, 32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);

        m0_addr = 32'h0000_0010; m0_req = 1'b1;
        cyc();
        chk("rd_addr", s_addr, 32'h0000_0010);
        chk("rd_we", 32'(s_we), 32'h0);
        serve(1'b0, 5'b00001, 32'h1234_5678, "ram_rd");
        chk("rd_idle", 32'({m0_gnt, m0_done}), 32'h0);

        pulse_rst();
        m0_addr = 32'h1000_0020; m1_addr = 32'h1000_0020;
        m0_req = 1'b1; m1_req = 1'b1;
        cyc();
        serve(1'b0, 5'b01000, 32'hAAAA_0000, "tie1_m0");
        cyc();
        serve(1'b1, 5'b01000, 32'hBBBB_0001, "tie1_m1");
        m0_req = 1'b1; m1_req = 1'b1;
        cyc();
        serve(1'b0, 5'b01000, 32'hAAAA_0002, "tie2_m0");
        cyc();
        serve(1'b1, 5'b01000, 32'hBBBB_0003, "tie2_m1");

        m1_we = 1'b1; m1_addr = 32'h1000_0010; m1_wdata = 32'hCAFE_F00D; m1_req = 1'b1;
        bData = 32'h5555_AAAA;
        cyc();
        chk("wr_wdata", s_wdata, 32'hCAFE_F00D);
        chk("wr_gnt", 32'({m1_gnt, m0_gnt}), 32'h2);
        for (int i = 1; i <= 4; i++) begin
            chk("wr_sel", 32'(bSel), 32'h4);
            chk("wr_we", 32'(s_we), 32'h1);
            chk("wr_nodone", 32'(m1_done), 32'h0);
            if (i == 4) s_ack = 5'b00100;
            cyc();
        end
        chk("wr_done", 32'({m1_done, m1_err}), 32'h2);
        chk("wr_sel_clr", 32'(bSel), 32'h0);
        chk("wr_we_clr", 32'(s_we), 32'h0);
        m1_req = 1'b0; m1_we = 1'b0; s_ack = 5'b0;
        cyc();

        m0_addr = 32'h2000_0000; m0_req = 1'b1;
        cyc();
        chk("unm_done", 32'({m0_done, m0_err}), 32'h3);
        chk("unm_gnt", 32'(m0_gnt), 32'h1);
        chk("unm_sel", 32'(bSel), 32'h0);
        chk("unm_rdata", m_rdata, 32'h0);
        chk("unm_addr", s_addr, 32'h0);
        m0_req = 1'b0;
        cyc();
        chk("unm_idle", 32'(m0_done), 32'h0);

        m0_addr = 32'h1000_0000; m0_req = 1'b1; s_ack = 5'b00001;
        cyc();
        chk("to_sel", 32'(bSel), 32'h2);
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int c = 2; c <= 15; c++) cyc();
        chk("to_c15_done", 32'(m0_done), 32'h0);
        chk("to_c15_sel", 32'(bSel), 32'h2);
        cyc();
        chk("to_c16_done", 32'({m0_done, m0_err}), 32'h3);
        chk("to_c16_rdata", m_rdata, 32'h0);
        chk("to_c16_sel", 32'(bSel), 32'h0);
        m0_req = 1'b0; s_ack = 5'b0;
        cyc();
`else
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (m0_done) seen++;
        end
        chk("nto_done", 32'(seen), 32'h0);
        chk("nto_sel", 32'(bSel), 32'h2);
        m0_req = 1'b0; s_ack = 5'b0;
        pulse_rst();
`endif

        m1_addr = 32'h0000_0100; m1_req = 1'b1;
        cyc();
        chk("ar_sel1", 32'(bSel), 32'h1);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sel", 32'(bSel), 32'h0);
        chk("ar_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
        chk("ar_done", 32'({m1_done, m0_done}), 32'h0);
        chk("ar_addr", s_addr, 32'h0);
        rst_n = 1'b1;
        cyc();
        serve(1'b1, 5'b00001, 32'h0BAD_F00D, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
